mul_seq_ctrl: RTL

//  Sequencer that runs an iterative unsigned shift-add multiply on one shared

---
 rtl/mul_seq_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// Iterative unsigned shift-add multiplier sequencer driving one external WIDTH-bit adder.
// One multiply per accepted start; W adder steps, then a one-cycle done with the product.
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mcand, acc_hi, mplr;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last    = (cnt == LAST);
  assign add_a   = acc_hi;
  assign add_b   = mplr[0] ? mcand : '0;
  assign add_cin = 1'b0;

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // {acc_hi,mplr} shifts right one bit per step with the adder carry entering the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      mplr    <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE && start) begin
      mcand  <= op_a;
      mplr   <= op_b;
      acc_hi <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc_hi <= {add_cout, add_sum[WIDTH-1:1]};
      mplr   <= {add_sum[0], mplr[WIDTH-1:1]};
      cnt    <= cnt + CW'(1);
      if (last) product <= {add_cout, add_sum, mplr[WIDTH-1:1]};
    end
  end
endmodule
